i2c_req_arbiter: RTL and testbench

//  Shares the single i2c_master between NREQ on-chip requesters (display/config writers, etc.).

---
 rtl/i2c_req_arbiter_if.sv | 33 +++
 rtl/i2c_req_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// Bundle between the requester-side clients, the arbiter and the i2c_master.
//   req/req_addr/req_dat/req_two : per-requester request level and write payload
//   gnt/done/err                 : one-hot grant and completion/abort pulses
//   m_start/m_restart/m_addr/m_dat : commands to the i2c_master
//   m_busy/m_running             : status from the i2c_master
// The master modport is the arbiter's view; slave is the environment's view.
interface i2c_req_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [8*NREQ-1:0]  req_addr;
  logic [16*NREQ-1:0] req_dat;
  logic [NREQ-1:0]    req_two;
  logic [NREQ-1:0]    gnt;
  logic               done;
  logic               err;
  logic               m_start;
  logic               m_restart;
  logic [7:0]         m_addr;
  logic [7:0]         m_dat;
  logic               m_busy;
  logic               m_running;

  modport master (
    input  req, req_addr, req_dat, req_two, m_busy, m_running,
    output gnt, done, err, m_start, m_restart, m_addr, m_dat
  );

  modport slave (
    output req, req_addr, req_dat, req_two, m_busy, m_running,
    input  gnt, done, err, m_start, m_restart, m_addr, m_dat
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NREQ requesters. The winner's payload is
// latched at grant and the master is sequenced through START, address byte, 1 or 2 data bytes,
// STOP. Completion is signalled with a done pulse, a stalled wait state with an err pulse.
//   clk, rst : system clock, synchronous active-high reset
//   bus_io   : requester handshake (req/payload in, gnt/done/err out) and i2c_master
//              command/status (m_start/m_restart/m_addr/m_dat out, m_busy/m_running in)
// All outputs are registered.
module i2c_req_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned TOUT = 4096,
  parameter int unsigned TW   = 13
) (
  input  logic              clk,
  input  logic              rst,
  i2c_req_arbiter_if.master bus_io
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StArb, StStart, StByte, StStop, StFin} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            m_start_q, m_start_d;
  logic [7:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_dat_q, m_dat_d;
  logic [7:0]      dat2_q, dat2_d;
  logic            two_q, two_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            busy_q;

  logic            busy_fall, busy_edge, tout;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [7:0]      pick_addr;
  logic [15:0]     pick_dat;
  logic            pick_two;

  assign busy_fall = busy_q & ~bus_io.m_busy;
  assign busy_edge = busy_q ^ bus_io.m_busy;
  // Fires on the cycle the counter would reach TOUT.
  assign tout      = (tmr_q == TW'(TOUT - 1));

  // Round-robin pick: lowest set request at/after rr_q, else lowest set request overall (wrap).
  always_comb begin
    logic          hi_vld;
    logic [PW-1:0] hi_idx, lo_idx;
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus_io.req[i]) begin
        lo_idx = PW'(i);
        if (PW'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
    pick_vld  = |bus_io.req;
    pick_idx  = hi_vld ? hi_idx : lo_idx;
    pick_addr = '0;
    pick_dat  = '0;
    pick_two  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (PW'(i) == pick_idx) begin
        pick_addr = bus_io.req_addr[8*i +: 8];
        pick_dat  = bus_io.req_dat[16*i +: 16];
        pick_two  = bus_io.req_two[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    m_start_d = m_start_q;
    m_addr_d  = m_addr_q;
    m_dat_d   = m_dat_q;
    dat2_d    = dat2_q;
    two_d     = two_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (|bus_io.req) state_d = StArb;
      end
      StArb: begin
        if (pick_vld) begin
          win_d     = pick_idx;
          gnt_d     = NREQ'(1) << pick_idx;
          m_addr_d  = pick_addr;
          m_dat_d   = pick_dat[7:0];
          dat2_d    = pick_dat[15:8];
          two_d     = pick_two;
          cnt_d     = '0;
          m_start_d = 1'b1;
          state_d   = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        if (tout) begin
          m_start_d = 1'b0;
          err_d     = 1'b1;
          state_d   = StFin;
        end else if (bus_io.m_running) begin
          state_d = StByte;
        end
      end
      StByte: begin
        if (tout) begin
          m_start_d = 1'b0;
          err_d     = 1'b1;
          state_d   = StFin;
        end else if (busy_fall) begin
          // cnt_q counts completed bytes before this edge; address byte is byte 0.
          if (cnt_q == (two_q ? 2'd2 : 2'd1)) begin
            m_start_d = 1'b0;
            state_d   = StStop;
          end else begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd1 && two_q) m_dat_d = dat2_q;
          end
        end
      end
      StStop: begin
        if (tout) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (!bus_io.m_running) begin
          done_d  = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        gnt_d   = '0;
        rr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (state_d != state_q || busy_edge ||
        !(state_q inside {StStart, StByte, StStop})) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      m_addr_q  <= '0;
      m_dat_q   <= '0;
      dat2_q    <= '0;
      two_q     <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      m_addr_q  <= m_addr_d;
      m_dat_q   <= m_dat_d;
      dat2_q    <= dat2_d;
      two_q     <= two_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      busy_q    <= bus_io.m_busy;
    end
  end

  assign bus_io.gnt       = gnt_q;
  assign bus_io.done      = done_q;
  assign bus_io.err       = err_q;
  assign bus_io.m_start   = m_start_q;
  assign bus_io.m_restart = 1'b0;
  assign bus_io.m_addr    = m_addr_q;
  assign bus_io.m_dat     = m_dat_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TOUT = 32;
  localparam int unsigned TW   = 6;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_rr;
  bit   mst_dead = 1'b0;

  logic [7:0]      addr_a [NREQ];
  logic [15:0]     dat_a  [NREQ];
  logic            two_a  [NREQ];
  logic [NREQ-1:0] req_v;
  logic [7:0]      mst_q[$];

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

  for (genvar g = 0; g < NREQ; g++) begin : g_pay
    assign bus.req_addr[8*g +: 8]  = addr_a[g];
    assign bus.req_dat[16*g +: 16] = dat_a[g];
    assign bus.req_two[g]          = two_a[g];
  end

  i2c_req_arbiter #(.NREQ(NREQ), .TOUT(TOUT), .TW(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: first set request at/after the pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int rr);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic mcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural i2c_master: keeps sending bytes while m_start stays high, records each byte.
  initial begin : master_model
    int nb;
    bus.m_busy    = 1'b0;
    bus.m_running = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && !mst_dead && bus.m_start && !bus.m_running) begin
        mcyc($urandom_range(1, 3));
        bus.m_running = 1'b1;
        nb = 0;
        do begin
          mcyc($urandom_range(1, 2));
          mst_q.push_back(nb == 0 ? bus.m_addr : bus.m_dat);
          bus.m_busy = 1'b1;
          mcyc($urandom_range(2, 5));
          bus.m_busy = 1'b0;
          mcyc($urandom_range(2, 3));
          nb++;
        end while (bus.m_start && nb < 4);
        mcyc($urandom_range(1, 3));
        bus.m_running = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_onehot0", 32'($countones(bus.gnt) <= 1), 1);
      check("done_err_excl", 32'(bus.done & bus.err), 0);
      check("m_restart_zero", 32'(bus.m_restart), 0);
    end
  end

  task automatic rand_payload(input int k);
    addr_a[k] = 8'($urandom);
    dat_a[k]  = 16'($urandom);
    two_a[k]  = 1'($urandom);
  endtask

  // One full transaction from the current req_v, checked against the model.
  task automatic do_txn(input bit drop_mid, input bit keep);
    int              w, c;
    logic [7:0]      exp_b[$];
    logic [NREQ-1:0] g_exp;
    bit              gnt_ok;
    w = model_pick(req_v, exp_rr);
    exp_b.delete();
    exp_b.push_back(addr_a[w]);
    exp_b.push_back(dat_a[w][7:0]);
    if (two_a[w]) exp_b.push_back(dat_a[w][15:8]);
    g_exp = NREQ'(1) << w;
    mst_q.delete();
    bus.req = req_v;
    c = 0;
    while (bus.gnt == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("gnt", 32'(bus.gnt), 32'(g_exp));
    check("m_addr", 32'(bus.m_addr), 32'(exp_b[0]));
    check("m_dat_first", 32'(bus.m_dat), 32'(exp_b[1]));
    check("m_start_on", 32'(bus.m_start), 1);
    // Changing the winner's payload now must not affect the transaction.
    rand_payload(w);
    if (drop_mid) begin
      c = 0;
      while (!bus.m_busy && c < 40) begin
        @(negedge clk);
        c++;
      end
      check("busy_seen", 32'(bus.m_busy), 1);
      req_v[w] = 1'b0;
      bus.req  = req_v;
    end
    gnt_ok = 1'b1;
    c = 0;
    while (!bus.done && !bus.err && c < 300) begin
      @(negedge clk);
      c++;
      if (bus.gnt !== g_exp) gnt_ok = 1'b0;
    end
    check("done", 32'(bus.done), 1);
    check("err_low", 32'(bus.err), 0);
    check("gnt_held", 32'(gnt_ok), 1);
    if (!keep) begin
      req_v[w] = 1'b0;
      bus.req  = req_v;
    end
    check("nbytes", mst_q.size(), exp_b.size());
    for (int k = 0; k < exp_b.size() && k < mst_q.size(); k++) begin
      check($sformatf("byte%0d", k), 32'(mst_q[k]), 32'(exp_b[k]));
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 0);
    check("gnt_clear", 32'(bus.gnt), 0);
    exp_rr = (w + 1) % NREQ;
  endtask

  initial begin : main
    int c, w;
    bit seen;
    logic [NREQ-1:0] g_exp;
    rst   = 1'b1;
    req_v = '0;
    bus.req = '0;
    for (int k = 0; k < int'(NREQ); k++) rand_payload(k);
    exp_rr = 0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_m_start", 32'(bus.m_start), 0);
    check("rst_m_restart", 32'(bus.m_restart), 0);
    check("rst_m_addr", 32'(bus.m_addr), 0);
    check("rst_m_dat", 32'(bus.m_dat), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single data byte, then two data bytes.
    addr_a[0] = 8'hA0; dat_a[0] = 16'h00AA; two_a[0] = 1'b0;
    req_v = 2'b01;
    do_txn(1'b0, 1'b0);
    addr_a[0] = 8'hA0; dat_a[0] = 16'h55AA; two_a[0] = 1'b1;
    req_v = 2'b01;
    do_txn(1'b0, 1'b0);

    // Random request patterns; pending requests carry over.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < int'(NREQ); k++) if (!req_v[k]) rand_payload(k);
      req_v = req_v | NREQ'($urandom_range(0, 3));
      if (req_v == '0) req_v = 2'b10;
      do_txn(1'b0, 1'b0);
    end
    while (req_v != '0) do_txn(1'b0, 1'b0);

    // Both requests held continuously: grants alternate.
    for (int t = 0; t < 3; t++) begin
      req_v = 2'b11;
      do_txn(1'b0, 1'b1);
    end
    while (req_v != '0) do_txn(1'b0, 1'b0);

    // Leave the pointer at 1, then reset mid-byte.
    rand_payload(0);
    req_v = 2'b01;
    do_txn(1'b0, 1'b0);
    rand_payload(0);
    req_v = 2'b01;
    bus.req = req_v;
    mst_q.delete();
    c = 0;
    while (bus.gnt == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("t5_gnt", 32'(bus.gnt), 32'(NREQ'(1) << model_pick(req_v, exp_rr)));
    c = 0;
    while (!bus.m_busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("t5_busy", 32'(bus.m_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_gnt_rst", 32'(bus.gnt), 0);
    check("t5_done_rst", 32'(bus.done), 0);
    check("t5_err_rst", 32'(bus.err), 0);
    check("t5_m_start_rst", 32'(bus.m_start), 0);
    check("t5_m_addr_rst", 32'(bus.m_addr), 0);
    check("t5_m_dat_rst", 32'(bus.m_dat), 0);
    req_v = '0;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (bus.m_running && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("t5_master_idle", 32'(bus.m_running), 0);
    exp_rr = 0;
    for (int k = 0; k < int'(NREQ); k++) rand_payload(k);
    req_v = 2'b11;
    do_txn(1'b0, 1'b0);
    while (req_v != '0) do_txn(1'b0, 1'b0);

    // Requester drops req mid-transaction.
    rand_payload(1);
    req_v = 2'b10;
    do_txn(1'b1, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt != '0) seen = 1'b1;
    end
    check("t6_no_regrant", 32'(seen), 0);

    // Master never responds: timeout abort.
    mst_dead = 1'b1;
    rand_payload(0);
    req_v = 2'b01;
    w = model_pick(req_v, exp_rr);
    g_exp = NREQ'(1) << w;
    bus.req = req_v;
    c = 0;
    while (bus.gnt == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("t4_gnt", 32'(bus.gnt), 32'(g_exp));
    check("t4_m_start", 32'(bus.m_start), 1);
    c = 0;
    seen = 1'b0;
    while (!bus.err && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.done) seen = 1'b1;
    end
    check("t4_tout_cycles", c, TOUT);
    check("t4_err", 32'(bus.err), 1);
    check("t4_m_start_off", 32'(bus.m_start), 0);
    check("t4_done_never", 32'(seen), 0);
    check("t4_gnt_held", 32'(bus.gnt), 32'(g_exp));
    req_v[w] = 1'b0;
    bus.req = req_v;
    @(negedge clk);
    check("t4_err_pulse", 32'(bus.err), 0);
    check("t4_gnt_clear", 32'(bus.gnt), 0);
    exp_rr = (w + 1) % NREQ;
    mst_dead = 1'b0;

    // Recovery after abort.
    for (int k = 0; k < int'(NREQ); k++) rand_payload(k);
    req_v = 2'b11;
    do_txn(1'b0, 1'b0);
    while (req_v != '0) do_txn(1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
